// File: rtl/cpu_hatch.sv
// Byte-serial program loader and 48-bit instruction store feeding the CPU fetch stage.
// Optional checksum byte after the data is enabled by defining HATCH_CHECKSUM_EN.
module cpu_hatch #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_restart,
  output logic              cpu_rst_b,
  output logic              load_err,
  output logic [ADDR_W:0]   loaded_count,
  input  logic [31:0]       hatch_address,
  output logic [47:0]       hatch_instruction
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [16:0] DepthW = 17'(Depth);
  localparam logic [ADDR_W:0] CntOne = 1;

  typedef enum logic [2:0] {StHdrHi, StHdrLo, StData, StChk, StRun, StErr} state_e;

`ifdef HATCH_CHECKSUM_EN
  localparam state_e StAfterData = StChk;
`else
  localparam state_e StAfterData = StRun;
`endif

  state_e state_q, state_d;

  logic [15:0]     n_q, n_d;
  logic [15:0]     word_cnt_q, word_cnt_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [39:0]     asm_q, asm_d;
  logic [7:0]      csum_q, csum_d;
  logic            err_q, err_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            cpu_rst_b_q;
  logic            fetch_ok_q;
  logic [47:0]     rd_q;
  logic [47:0]     mem [Depth];

  logic            xfer;
  logic            last_word;
  logic            wr_en;
  logic [47:0]     wr_word;
  logic [15:0]     n_full;

  assign xfer      = load_valid && load_ready;
  assign last_word = (byte_cnt_q == 3'd5) && (word_cnt_q == n_q - 16'd1);
  assign n_full    = {n_q[15:8], load_byte};

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= StHdrHi;
    else        state_q <= state_d;
  end

  // Next-state logic; restart wins over a simultaneous byte
  always_comb begin
    state_d = state_q;
    if (load_restart) begin
      state_d = StHdrHi;
    end else if (xfer) begin
      unique case (state_q)
        StHdrHi: state_d = StHdrLo;
        StHdrLo: state_d = (n_full == 16'd0) ? StAfterData : StData;
        StData:  if (last_word) state_d = StAfterData;
        StChk:   state_d = (load_byte == csum_q) ? StRun : StErr;
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    load_ready        = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                        (state_q == StData)  || (state_q == StChk);
    cpu_rst_b         = cpu_rst_b_q;
    load_err          = err_q;
    loaded_count      = cnt_q;
    hatch_instruction = (fetch_ok_q && cpu_rst_b_q) ? rd_q : 48'h0;
  end

  // Datapath next-state: header, assembler, counters, checksum
  always_comb begin
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_word    = {asm_q, load_byte};
    if (load_restart) begin
      n_d        = 16'd0;
      word_cnt_d = 16'd0;
      byte_cnt_d = 3'd0;
      csum_d     = 8'd0;
      err_d      = 1'b0;
      cnt_d      = '0;
    end else if (xfer) begin
      unique case (state_q)
        StHdrHi: n_d = {load_byte, n_q[7:0]};
        StHdrLo: begin
          n_d        = n_full;
          word_cnt_d = 16'd0;
          byte_cnt_d = 3'd0;
          csum_d     = 8'd0;
          cnt_d      = '0;
          if ({1'b0, n_full} > DepthW) err_d = 1'b1;
        end
        StData: begin
          asm_d  = {asm_q[31:0], load_byte};
          csum_d = csum_q ^ load_byte;
          if (byte_cnt_q == 3'd5) begin
            byte_cnt_d = 3'd0;
            word_cnt_d = word_cnt_q + 16'd1;
            // Words past capacity are consumed but never written
            if ({1'b0, word_cnt_q} < DepthW) begin
              wr_en = 1'b1;
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
        StChk:   if (load_byte != csum_q) err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      n_q         <= 16'd0;
      word_cnt_q  <= 16'd0;
      byte_cnt_q  <= 3'd0;
      asm_q       <= 40'd0;
      csum_q      <= 8'd0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cpu_rst_b_q <= 1'b0;
      fetch_ok_q  <= 1'b0;
    end else begin
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cpu_rst_b_q <= (state_q == StRun) && !load_restart;
      fetch_ok_q  <= (state_q == StRun) && (hatch_address < 32'(cnt_q));
    end
  end

  // Synchronous instruction RAM; contents survive reset and restart
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_cnt_q[ADDR_W-1:0]] <= wr_word;
    rd_q <= mem[hatch_address[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_cpu_hatch.sv
// Randomized bench for cpu_hatch: byte-accounting reference model checked every cycle,
// plus literal expectations. Follows HATCH_CHECKSUM_EN like the design.
module tb_cpu_hatch;
  localparam int AW  = 2;
  localparam int DEP = 4;
`ifdef HATCH_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h0;
  logic        load_restart = 1'b0;
  logic [31:0] hatch_address = 32'h0;
  logic        load_ready, cpu_rst_b, load_err;
  logic [AW:0] loaded_count;
  logic [47:0] hatch_instruction;

  cpu_hatch #(.ADDR_W(AW)) dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .load_valid        (load_valid),
    .load_byte         (load_byte),
    .load_ready        (load_ready),
    .load_restart      (load_restart),
    .cpu_rst_b         (cpu_rst_b),
    .load_err          (load_err),
    .loaded_count      (loaded_count),
    .hatch_address     (hatch_address),
    .hatch_instruction (hatch_instruction)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the image purely by bytes taken so far
  int          nbytes, nhdr, cnt_m;
  logic [47:0] mem_m [DEP];
  logic [47:0] asm_m;
  logic [7:0]  csum_m;
  bit          err_m, run_m, errst_m, crst_m;
  logic [47:0] fetch_m;

  task automatic m_restart();
    nbytes = 0; nhdr = 0; cnt_m = 0; asm_m = 48'h0; csum_m = 8'h0;
    err_m = 1'b0; run_m = 1'b0; errst_m = 1'b0;
  endtask

  task automatic m_take(input logic [7:0] b);
    int idx;
    if (nbytes == 0) begin
      nhdr = int'(b) * 256;
    end else if (nbytes == 1) begin
      nhdr = nhdr + int'(b);
      if (nhdr > DEP) err_m = 1'b1;
      if (nhdr == 0 && !CK) run_m = 1'b1;
    end else begin
      idx = nbytes - 2;
      if (idx < 6 * nhdr) begin
        asm_m  = {asm_m[39:0], b};
        csum_m = csum_m ^ b;
        if (idx % 6 == 5) begin
          if (idx / 6 < DEP) begin
            mem_m[idx / 6] = asm_m;
            cnt_m++;
          end
          if (idx == 6 * nhdr - 1 && !CK) run_m = 1'b1;
        end
      end else if (b == csum_m) begin
        run_m = 1'b1;
      end else begin
        err_m = 1'b1; errst_m = 1'b1;
      end
    end
    nbytes++;
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_restart();
      crst_m  = 1'b0;
      fetch_m = 48'h0;
    end else begin : model_step
      bit          v, crst_n;
      logic [47:0] rdat;
      v      = run_m && (hatch_address < 32'(cnt_m));
      rdat   = mem_m[hatch_address[AW-1:0]];
      crst_n = run_m && !load_restart;
      if (load_restart) m_restart();
      else if (load_valid && !run_m && !errst_m) m_take(load_byte);
      crst_m  = crst_n;
      fetch_m = (v && crst_n) ? rdat : 48'h0;
    end
  end

  always @(negedge clk) begin
    check("load_ready", 64'(load_ready), 64'(!run_m && !errst_m));
    check("cpu_rst_b", 64'(cpu_rst_b), 64'(crst_m));
    check("load_err", 64'(load_err), 64'(err_m));
    check("loaded_count", 64'(loaded_count), 64'(cnt_m));
    check("hatch_instruction", 64'(hatch_instruction), 64'(fetch_m));
  end

  // Stimulus helpers; all drive at posedge+1
  logic [47:0] img [8];

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk); #1;
    end
    load_valid = 1'b1; load_byte = b;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input int gap, input bit good_ck);
    logic [7:0]  x;
    logic [47:0] w;
    x = 8'h0;
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 6; j++) begin
        x = x ^ w[47 - 8 * j -: 8];
        send_byte(w[47 - 8 * j -: 8], gap);
      end
    end
    if (CK) send_byte(good_ck ? x : (x ^ 8'h01), gap);
  endtask

  task automatic fetch_lit(input logic [31:0] a, input logic [47:0] exp);
    hatch_address = a;
    @(posedge clk); #1;
    check("fetch_lit", 64'(hatch_instruction), 64'(exp));
  endtask

  task automatic pulse_restart();
    load_restart = 1'b1;
    @(posedge clk); #1;
    load_restart = 1'b0;
  endtask

  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
  endtask

  task automatic fetch_sweep(input int cycles);
    repeat (cycles) begin
      hatch_address = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    hatch_address = 32'h0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEP; i++) mem_m[i] = 48'h0;
    m_restart();
    crst_m = 1'b0; fetch_m = 48'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(load_ready), 64'd1);
    check("rst_cpu_rst_b", 64'(cpu_rst_b), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_count", 64'(loaded_count), 64'd0);
    check("rst_instr", 64'(hatch_instruction), 64'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Basic two-word load, back-to-back bytes
    img[0] = 48'h010203040506;
    img[1] = 48'hA0A1A2A3A4A5;
    send_image(2, 0, 1'b1);
    check("crst_low_at_last", 64'(cpu_rst_b), 64'd0);
    @(posedge clk); #1;
    check("crst_rises", 64'(cpu_rst_b), 64'd1);
    fetch_lit(32'd0, 48'h010203040506);
    fetch_lit(32'd1, 48'hA0A1A2A3A4A5);
    fetch_lit(32'd2, 48'h0);
    fetch_lit(32'h8000_0001, 48'h0);

    // Bytes offered in RUN must be ignored
    repeat (10) begin
      load_valid = 1'b1; load_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    check("run_count_kept", 64'(loaded_count), 64'd2);
    check("run_not_ready", 64'(load_ready), 64'd0);

    // Random image, random gaps, then the same image again
    for (int k = 0; k < 3; k++) begin
      pulse_restart();
      n = $urandom_range(1, 4);
      rand_img(n);
      send_image(n, 3, 1'b1);
      @(posedge clk); #1;
      fetch_sweep(30);
      pulse_restart();
      send_image(n, 1, 1'b1);
      @(posedge clk); #1;
      fetch_lit(32'(n - 1), img[n - 1]);
      fetch_sweep(20);
    end

    // Oversize image
    pulse_restart();
    rand_img(5);
    send_image(5, 1, 1'b1);
    check("ovf_err", 64'(load_err), 64'd1);
    check("ovf_count", 64'(loaded_count), 64'd4);
    @(posedge clk); #1;
    fetch_lit(32'd0, img[0]);
    fetch_lit(32'd3, img[3]);
    fetch_lit(32'd4, 48'h0);

    // Restart colliding with a byte mid-DATA
    pulse_restart();
    rand_img(3);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int j = 0; j < 7; j++) send_byte(8'($urandom), 1);
    load_valid = 1'b1; load_byte = 8'h5A; load_restart = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; load_restart = 1'b0;
    check("rs_cpu_rst_b", 64'(cpu_rst_b), 64'd0);
    check("rs_ready", 64'(load_ready), 64'd1);
    check("rs_count", 64'(loaded_count), 64'd0);
    rand_img(1);
    send_image(1, 2, 1'b1);
    @(posedge clk); #1;
    fetch_lit(32'd0, img[0]);
    fetch_lit(32'd1, 48'h0);

    // Asynchronous reset mid-load abandons the image
    pulse_restart();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    rand_img(2);
    send_image(2, 1, 1'b1);
    @(posedge clk); #1;
    fetch_lit(32'd1, img[1]);

    if (CK) begin
      pulse_restart();
      rand_img(2);
      send_image(2, 0, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      check("ck_err", 64'(load_err), 64'd1);
      check("ck_cpu_rst_b", 64'(cpu_rst_b), 64'd0);
      check("ck_ready", 64'(load_ready), 64'd0);
    end

    // Empty image
    pulse_restart();
    send_image(0, 0, 1'b1);
    @(posedge clk); #1;
    check("n0_cpu_rst_b", 64'(cpu_rst_b), 64'd1);
    check("n0_count", 64'(loaded_count), 64'd0);
    for (int a = 0; a < 6; a++) fetch_lit(32'(a), 48'h0);
    fetch_sweep(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
